// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: four-phase SCL period from a fixed clk divider,
// open-drain drive via scl_oe, clock-stretch hold with a sticky timeout flag.
module i2c_scl_gen #(
  parameter int DIVIDER = 250,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 10000,
  parameter int TO_W    = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       scl_in,
  input  logic       err_clr,
  output logic       scl_oe,
  output logic       data_clk,
  output logic       switch_range,
  output logic [1:0] phase,
  output logic       stretching,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STRETCH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] Q1      = CNT_W'(DIVIDER);
  localparam logic [CNT_W-1:0] Q2      = CNT_W'(2 * DIVIDER);
  localparam logic [CNT_W-1:0] Q3      = CNT_W'(3 * DIVIDER);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(4 * DIVIDER - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             scl_oe_q, scl_oe_d;
  logic             data_clk_q, data_clk_d;
  logic             switch_range_q, switch_range_d;
  logic [1:0]       phase_q, phase_d;
  logic             stretching_q, stretching_d;
  logic             busy_q, busy_d;
  logic             run_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q & ~err_clr;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ena) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) begin
          // Stop is only honoured at the period boundary.
          cnt_d = '0;
          if (!ena) state_d = IDLE;
        end else if (cnt_q == Q2 && !scl_in) begin
          state_d  = STRETCH;
          to_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STRETCH: begin
        if (scl_in) begin
          state_d = RUN;
          cnt_d   = Q2 + 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the flops present the
    // current state's decode without any input-to-output path.
    run_d          = (state_d != IDLE);
    scl_oe_d       = run_d && (cnt_d < Q2);
    data_clk_d     = run_d && (cnt_d >= Q1) && (cnt_d < Q3);
    switch_range_d = run_d && (cnt_d >= Q2) && (cnt_d < Q3);
    if (!run_d)          phase_d = 2'd0;
    else if (cnt_d < Q1) phase_d = 2'd0;
    else if (cnt_d < Q2) phase_d = 2'd1;
    else if (cnt_d < Q3) phase_d = 2'd2;
    else                 phase_d = 2'd3;
    stretching_d   = (state_d == STRETCH);
    busy_d         = run_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      to_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
      scl_oe_q       <= 1'b0;
      data_clk_q     <= 1'b0;
      switch_range_q <= 1'b0;
      phase_q        <= 2'd0;
      stretching_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_cnt_q       <= to_cnt_d;
      timeout_err_q  <= timeout_err_d;
      scl_oe_q       <= scl_oe_d;
      data_clk_q     <= data_clk_d;
      switch_range_q <= switch_range_d;
      phase_q        <= phase_d;
      stretching_q   <= stretching_d;
      busy_q         <= busy_d;
    end
  end

  assign scl_oe       = scl_oe_q;
  assign data_clk     = data_clk_q;
  assign switch_range = switch_range_q;
  assign phase        = phase_q;
  assign stretching   = stretching_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen (DIVIDER=4, TIMEOUT=8): period-level reference model
// pushes per-cycle expected outputs; a monitor pops and compares each cycle.
module tb_i2c_scl_gen;

  localparam int D  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       scl_in = 1'b1;
  logic       err_clr = 1'b0;
  logic       scl_oe, data_clk, switch_range, stretching, busy, timeout_err;
  logic [1:0] phase, state_dbg;

  // Packed view: {scl_oe, data_clk, switch_range, phase, stretching, busy, timeout_err}
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         m_err   = 1'b0;
  bit         clr_rand = 1'b1;

  i2c_scl_gen #(.DIVIDER(D), .CNT_W(5), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .scl_in(scl_in), .err_clr(err_clr),
    .scl_oe(scl_oe), .data_clk(data_clk), .switch_range(switch_range),
    .phase(phase), .stretching(stretching), .busy(busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Output pattern for a running cycle at period position pos.
  function automatic logic [7:0] run_out(int pos, bit str, bit err);
    logic [1:0] ph;
    ph = 2'(pos / D);
    return {pos < 2*D, pos >= D && pos <= 3*D-1, pos >= 2*D && pos <= 3*D-1,
            ph, str, 1'b1, err};
  endfunction

  function automatic logic [7:0] idle_out(bit err);
    return {7'b0, err};
  endfunction

  // Monitor: one expected entry per clock, checked away from the edge.
  always @(posedge clk) begin
    logic [7:0] got, exp;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {scl_oe, data_clk, switch_range, phase, stretching, busy, timeout_err};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cyc%0d outputs {oe,dclk,sw,ph,str,busy,err}: got %b expected %b",
                 cyc, got, exp);
      end
    end
  end

  task automatic rst_cycles(input int m);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      rst = 1'b1; ena = 1'($urandom_range(0, 1));
      scl_in = 1'($urandom_range(0, 1)); err_clr = 1'($urandom_range(0, 1));
      m_err = 1'b0;
      exp_q.push_back(idle_out(1'b0));
    end
  endtask

  // Idle for m cycles; if start, ena is raised on the last one.
  task automatic idle_cycles(input int m, input bit start, input int clr_at);
    bit last;
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      last = (i == m - 1);
      rst = 1'b0; ena = start && last;
      scl_in = 1'($urandom_range(0, 1));
      err_clr = (i == clr_at);
      if (err_clr) m_err = 1'b0;
      exp_q.push_back((start && last) ? run_out(0, 1'b0, m_err) : idle_out(m_err));
    end
  endtask

  // One SCL period starting with the DUT showing position 0. n > TO means a
  // timeout. ena_mode 1 drops ena at cycle 5 and re-raises it at cycle 12.
  task automatic run_period(input int n, input bit cont, input int ena_mode,
                            input int rst_at, output bit running);
    bit to, set;
    int ns, len, low_end, p;
    to      = (n > TO);
    ns      = to ? TO : n;
    len     = to ? 2*D + 1 + TO : 4*D + n;
    low_end = to ? len : 2*D + n;
    running = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      rst = 1'b0;
      if (k >= 2*D && k < low_end) scl_in = 1'b0;
      else if (k == low_end)       scl_in = 1'b1;
      else                         scl_in = 1'($urandom_range(0, 1));
      if (!to && k == len - 1) ena = cont;
      else if (ena_mode == 1)  ena = !(k >= 5 && k < 12);
      else                     ena = 1'($urandom_range(0, 1));
      err_clr = clr_rand && ($urandom_range(0, 3) == 0);
      if (k == rst_at) begin
        rst = 1'b1;
        m_err = 1'b0;
        exp_q.push_back(idle_out(1'b0));
        return;
      end
      set = to && (k == len - 1);
      m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
      p = k + 1;
      if (p < len) begin
        exp_q.push_back(run_out(p <= 2*D ? p : (p <= 2*D + ns ? 2*D : p - ns),
                                p > 2*D && p <= 2*D + ns, m_err));
      end else if (!to && cont) begin
        exp_q.push_back(run_out(0, 1'b0, m_err));
        running = 1'b1;
      end else begin
        exp_q.push_back(idle_out(m_err));
      end
    end
  endtask

  initial begin
    bit running;
    int n;
    rst_cycles(3);
    idle_cycles(20, 1'b0, -1);
    idle_cycles(1, 1'b1, -1);

    // Free run, stretches (including rise-time and full-length), then timeout.
    for (int i = 0; i < 3; i++) run_period(0, 1'b1, 0, -1, running);
    run_period(5, 1'b1, 0, -1, running);
    run_period(1, 1'b1, 0, -1, running);
    run_period(TO, 1'b1, 0, -1, running);
    clr_rand = 1'b0;
    run_period(TO + 1, 1'b1, 0, -1, running);
    idle_cycles(6, 1'b0, 4);
    idle_cycles(1, 1'b1, -1);

    // Graceful stop behaviour.
    run_period(0, 1'b1, 1, -1, running);
    run_period(0, 1'b0, 0, -1, running);
    idle_cycles(3, 1'b1, -1);

    // Timeout, immediate restart with the flag still set, reset mid-stretch.
    run_period(TO + 1, 1'b1, 0, -1, running);
    idle_cycles(1, 1'b1, -1);
    run_period(TO + 1, 1'b1, 0, 2*D + 3, running);
    idle_cycles(4, 1'b1, -1);
    clr_rand = 1'b1;

    // Random periods.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3) == 0 ? $urandom_range(0, TO + 1) : 0;
      run_period(n, $urandom_range(0, 3) != 0, 0,
                 $urandom_range(0, 19) == 0 ? $urandom_range(0, 10) : -1, running);
      if (!running) idle_cycles($urandom_range(1, 4), 1'b1, -1);
    end

    @(negedge clk);
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
